// File: rtl/timing_decode_unit_pkg.sv
// Shared control-path constants for the timing/decode stage and the
// downstream control-signal decoder: field positions, SC/T widths, opcodes.
package cpu_ctrl_pkg;

    localparam int SC_W      = 3;
    localparam int T_W       = 8;
    localparam int IR_W      = 16;

    localparam int IR_I_BIT  = 15;
    localparam int IR_OP_MSB = 14;
    localparam int IR_OP_LSB = 12;
    localparam int IR_B_MSB  = 7;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

endpackage

// File: rtl/timing_decode_unit_if.sv
// Fetch handshake, execute controls and decode outputs of the timing/decode
// stage. master = stimulus/execute side, slave = timing_decode_unit.
interface timing_decode_unit_if;
    import cpu_ctrl_pkg::*;

    logic [IR_W-1:0] mem_data;
    logic            mem_valid;
    logic            clr_sc;
    logic            hlt;
    logic            fetch_req;
    logic [T_W-1:0]  T;
    logic [7:0]      D;
    logic            I;
    logic [7:0]      B;
    logic [IR_W-1:0] ir;
    logic            sc_ovf;

    modport master (
        output mem_data, mem_valid, clr_sc, hlt,
        input  fetch_req, T, D, I, B, ir, sc_ovf
    );

    modport slave (
        input  mem_data, mem_valid, clr_sc, hlt,
        output fetch_req, T, D, I, B, ir, sc_ovf
    );

endinterface

// File: rtl/timing_decode_unit_onehot_dec3to8.sv
// 3-to-8 one-hot decoder, used for SC->T and opcode->D.
module onehot_dec3to8 (
    input  logic [2:0] sel_i,
    output logic [7:0] onehot_o
);

    // Single set bit at the position given by sel_i.
    always_comb begin
        onehot_o = 8'h01 << sel_i;
    end

endmodule

// File: rtl/timing_decode_unit.sv
// Timing/decode stage: holds IR and the sequence counter SC, and presents
// one-hot T, one-hot D, I and B combinationally from those registers.
// Optional: TDU_WAIT_STATE_EN enables the T1 fetch stall on !mem_valid;
// without it mem_valid is ignored and IR loads at T1 unconditionally.
module timing_decode_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    timing_decode_unit_if.slave bus
);

    logic [SC_W-1:0] sc_q, sc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            ovf_q, ovf_d;
    logic            at_t1;
    logic            stall;

    assign at_t1 = (sc_q == SC_W'(1));

`ifdef TDU_WAIT_STATE_EN
    assign stall = at_t1 && !bus.mem_valid;
`else
    assign stall = 1'b0;
`endif

    // SC priority clr_sc > hlt > stall > increment; IR loads on the T1 advance.
    always_comb begin
        sc_d  = sc_q;
        ir_d  = ir_q;
        ovf_d = ovf_q;
        if (bus.clr_sc) begin
            sc_d = '0;
        end else if (bus.hlt || stall) begin
            sc_d = sc_q;
        end else begin
            sc_d = sc_q + SC_W'(1);
            if (sc_q == SC_W'(T_W - 1))
                ovf_d = 1'b1;
            if (at_t1)
                ir_d = bus.mem_data;
        end
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q  <= '0;
            ir_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            ir_q  <= ir_d;
            ovf_q <= ovf_d;
        end
    end

    onehot_dec3to8 u_t_dec (.sel_i(sc_q),                    .onehot_o(bus.T));
    onehot_dec3to8 u_d_dec (.sel_i(ir_q[IR_OP_MSB:IR_OP_LSB]), .onehot_o(bus.D));

    assign bus.fetch_req = at_t1 && !bus.hlt;
    assign bus.I         = ir_q[IR_I_BIT];
    assign bus.B         = ir_q[IR_B_MSB:0];
    assign bus.ir        = ir_q;
    assign bus.sc_ovf    = ovf_q;

endmodule

// File: tb/tb_timing_decode_unit.sv
// Scoreboard bench for timing_decode_unit: directed test-plan sequences plus
// random traffic, checked against an instruction-cycle model.
module tb_timing_decode_unit;

`ifdef TDU_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    timing_decode_unit_if bus ();

    timing_decode_unit dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0]  t;
        logic [7:0]  d;
        logic        i;
        logic [7:0]  b;
        logic [15:0] ir;
        logic        ovf;
        logic        fr;
        int          step_no;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int n_steps  = 0;

    // Instruction-cycle model: timing phase number, instruction word, overflow flag.
    int          m_phase = 0;
    logic [15:0] m_ir    = 16'h0;
    bit          m_ovf   = 1'b0;

    task automatic chk(input string name, input int sn, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, sn, act, req);
        end
    endtask

    // Drive one cycle of inputs and predict the state after the next edge.
    task automatic step(input bit r, input bit c, input bit h, input bit mv, input logic [15:0] dat);
        exp_t e;
        @(negedge clk);
        rst = r; bus.clr_sc = c; bus.hlt = h; bus.mem_valid = mv; bus.mem_data = dat;
        if (r) begin
            m_phase = 0; m_ir = 16'h0; m_ovf = 1'b0;
        end else if (c) begin
            m_phase = 0;
        end else if (h) begin
            // frozen
        end else if (WAIT_EN && m_phase == 1 && !mv) begin
            // waiting for memory
        end else begin
            if (m_phase == 1) m_ir = dat;
            if (m_phase == 7) m_ovf = 1'b1;
            m_phase = (m_phase + 1) % 8;
        end
        e.t       = 8'(1 << m_phase);
        e.d       = 8'(1 << m_ir[14:12]);
        e.i       = m_ir[15];
        e.b       = m_ir[7:0];
        e.ir      = m_ir;
        e.ovf     = m_ovf;
        e.fr      = (m_phase == 1) && !h;
        e.step_no = n_steps++;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [15:0] dat);
        for (int k = 0; k < n; k++) step(0, 0, 0, 1, dat);
    endtask

    // Monitor: every edge the DUT presents a new state; compare with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("T",         e.step_no, {8'h0, bus.T},     {8'h0, e.t});
                chk("D",         e.step_no, {8'h0, bus.D},     {8'h0, e.d});
                chk("I",         e.step_no, {15'h0, bus.I},    {15'h0, e.i});
                chk("B",         e.step_no, {8'h0, bus.B},     {8'h0, e.b});
                chk("ir",        e.step_no, bus.ir,            e.ir);
                chk("sc_ovf",    e.step_no, {15'h0, bus.sc_ovf},   {15'h0, e.ovf});
                chk("fetch_req", e.step_no, {15'h0, bus.fetch_req}, {15'h0, e.fr});
            end
        end
    end

    initial begin
        rst = 1'b1; bus.clr_sc = 1'b0; bus.hlt = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = 16'h0;

        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);

        // Reset mid-instruction at T5.
        run(5, 16'h1234);
        step(1, 1, 1, 1, 16'hFFFF);

        // Normal fetch of 7008, clr_sc at T3.
        run(3, 16'h7008);
        step(0, 1, 0, 1, 16'h0);

        // Fetch with memory not ready for 3 cycles, then 9123.
        step(0, 0, 0, 0, 16'h0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 1, 16'h9123);
        run(1, 16'h0);
        step(0, 1, 0, 1, 16'h0);

        // hlt during a T1 wait: SC stays, fetch_req drops, IR unchanged.
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 16'h5555);
        step(0, 0, 1, 1, 16'h5555);
        step(0, 1, 0, 1, 16'h0);

        // clr_sc + hlt together at T4, held halt, then release.
        run(4, 16'h2345);
        step(0, 1, 1, 1, 16'h0);
        step(0, 0, 1, 1, 16'h0);
        step(0, 0, 1, 1, 16'h0);
        run(3, 16'h6001);

        // Overflow: from T0 run 8 increments, then a clr_sc wrap, then reset.
        step(0, 1, 0, 1, 16'h0);
        run(8, 16'hA0F0);
        run(3, 16'h3333);
        step(0, 1, 0, 1, 16'h0);
        run(2, 16'h0);
        step(1, 0, 0, 0, 16'h0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 16'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
